// File: rtl/mem_arb_pkg.sv
// Shared types for the byte-serial memory port arbiter: sequencer states, owner, lane helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

   typedef enum logic {OWN_I, OWN_D} owner_t;

   // Big-endian: byte index 0 (lowest address) lands in the most significant lane.
   function automatic int unsigned byte_lane(input int unsigned width, input int unsigned idx);
      return width - 32'd8 - 32'd8 * idx;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-requester picker: fixed D-over-I priority, or round-robin when ARB_RR_EN is defined.
// Combinational pick; the round-robin pointer only moves when the sequencer reports a served word.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_vld_i,
   input  logic   d_vld_i,
   input  logic   upd_i,
   input  owner_t served_i,
   output logic   vld_o,
   output owner_t pick_o
);

   assign vld_o = i_vld_i | d_vld_i;

`ifdef ARB_RR_EN
   owner_t last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (upd_i) begin
         last_d = served_i;
      end
   end

   // Reset to D so that I wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWN_D;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      pick_o = OWN_D;
      if (i_vld_i && d_vld_i) begin
         pick_o = (last_q == OWN_D) ? OWN_I : OWN_D;
      end else if (i_vld_i) begin
         pick_o = OWN_I;
      end
   end
`else
   logic unused_rr;
   assign unused_rr = &{1'b0, clk, rst, upd_i, served_i};
   assign pick_o    = (d_vld_i || !i_vld_i) ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide single-port memory between fetch (I) and load/store (D), one word per grant.
// Done arrives WIDTH/8+2 cycles after the request is sampled in IDLE; ARB_RR_EN selects round-robin ties.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int WIDTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic              i_done,
   output logic [WIDTH-1:0]  i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [WIDTH-1:0]  d_wdata,
   output logic              d_done,
   output logic [WIDTH-1:0]  d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam int N     = WIDTH / 8;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [WIDTH-1:0] BYTE_MASK = WIDTH'(8'hFF);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              we_q, we_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  rbuf_q, rbuf_d;
   logic [WIDTH-1:0]  i_rdata_q, i_rdata_d;
   logic [WIDTH-1:0]  d_rdata_q, d_rdata_d;
   logic [WIDTH-1:0]  word;
   logic              i_kill;
   logic              pick_vld;
   owner_t            pick;
   int unsigned       lane;

   arb_pick u_pick (
      .clk      (clk),
      .rst      (rst),
      .i_vld_i  (i_req & ~i_flush),
      .d_vld_i  (d_req),
      .upd_i    (state_q == RESP),
      .served_i (owner_q),
      .vld_o    (pick_vld),
      .pick_o   (pick)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      base_d    = base_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      rbuf_d    = rbuf_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      lane      = 0;
      // The final byte always lands in lane 0 and is merged straight from the memory port.
      word      = (rbuf_q & ~BYTE_MASK) | WIDTH'(mem_rdata);
      i_kill    = (owner_q == OWN_I) && i_flush;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               owner_d = pick;
               base_d  = (pick == OWN_D) ? d_addr : i_addr;
               we_d    = (pick == OWN_D) && d_we;
               wdata_d = d_wdata;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mem_addr = base_q + ADDR_W'(cnt_q);
            if (we_q) begin
               mem_we    = 1'b1;
               mem_wdata = 8'(wdata_q >> byte_lane(WIDTH, int'(cnt_q)));
            end else begin
               mem_re = 1'b1;
               if (cnt_q != '0) begin
                  lane   = byte_lane(WIDTH, int'(cnt_q) - 1);
                  rbuf_d = (rbuf_q & ~(BYTE_MASK << lane)) | (WIDTH'(mem_rdata) << lane);
               end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DRAIN;
            end
            if (i_kill) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (i_kill) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
               if (!we_q) begin
                  if (owner_q == OWN_I) begin
                     i_rdata_d = word;
                  end else begin
                     d_rdata_d = word;
                  end
               end
            end
         end
         RESP: begin
            state_d = IDLE;
            if (owner_q == OWN_D) begin
               d_done = 1'b1;
            end else begin
               i_done = !i_flush;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_D;
         base_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         rbuf_q    <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         base_q    <= base_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         rbuf_q    <= rbuf_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (WIDTH=32, ADDR_W=8 so address wrap is reachable).
module tb_mem_port_arbiter;

   localparam bit P_I = 1'b0;
   localparam bit P_D = 1'b1;

   typedef struct {
      bit          port;
      int          cyc;
      logic [31:0] data;
      bit          load;
   } resp_t;

   typedef struct {
      int         cyc;
      logic [7:0] addr;
      bit         we;
      logic [7:0] wdata;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_flush, i_done;
   logic [7:0]  i_addr;
   logic [31:0] i_rdata;
   logic        d_req, d_we, d_done;
   logic [7:0]  d_addr;
   logic [31:0] d_wdata, d_rdata;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        mem_re, mem_we;

   logic [7:0]  mem [256];
   logic [7:0]  ref_mem [256];
   resp_t       resp_q[$];
   acc_t        acc_q[$];
   bit          last_port;
   int          cyc = 0;
   int          ign_lo = -1, ign_hi = -1;
   int          checks = 0, failures = 0;

   mem_port_arbiter #(.ADDR_W(8), .WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory macro: one-cycle read latency.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: a word transaction started at cycle t touches addr..addr+3 at t+1..t+4, done at t+6.
   function automatic void model_txn(input bit port, input bit we, input logic [7:0] addr,
                                     input logic [31:0] wdata, input int t);
      resp_t       r;
      acc_t        a;
      logic [31:0] w;
      logic [7:0]  ba;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         ba      = addr + 8'(k);
         a.cyc   = t + 1 + k;
         a.addr  = ba;
         a.we    = we;
         a.wdata = wdata[31 - 8*k -: 8];
         acc_q.push_back(a);
         if (we) ref_mem[ba] = a.wdata;
         else    w = {w[23:0], ref_mem[ba]};
      end
      r.port = port;
      r.cyc  = t + 6;
      r.data = w;
      r.load = !we;
      resp_q.push_back(r);
      last_port = port;
   endfunction

   task automatic do_txn(input bit port, input bit we, input logic [7:0] addr, input logic [31:0] wdata);
      model_txn(port, we, addr, wdata, cyc);
      if (port == P_D) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      repeat (7) tick();
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   task automatic do_tie(input logic [7:0] ia, input bit dwe, input logic [7:0] da, input logic [31:0] dwd);
      bit first;
      int t;
      t = cyc;
`ifdef ARB_RR_EN
      first = (last_port == P_D) ? P_I : P_D;
`else
      first = P_D;
`endif
      if (first == P_D) begin
         model_txn(P_D, dwe, da, dwd, t);
         model_txn(P_I, 1'b0, ia, '0, t + 7);
      end else begin
         model_txn(P_I, 1'b0, ia, '0, t);
         model_txn(P_D, dwe, da, dwd, t + 7);
      end
      i_req = 1'b1; i_addr = ia;
      d_req = 1'b1; d_we = dwe; d_addr = da; d_wdata = dwd;
      repeat (7) tick();
      if (first == P_D) d_req = 1'b0; else i_req = 1'b0;
      repeat (7) tick();
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_i_done"}, i_done, 0);
      chk({tag, "_d_done"}, d_done, 0);
      chk({tag, "_strobes"}, {mem_re, mem_we}, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_i_rdata"}, i_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
   endtask

   // Monitor: compare every done pulse and every memory strobe against the queued expectations.
   resp_t mr;
   acc_t  ma;
   always @(negedge clk) begin
      if (!rst) begin
         if (i_done || d_done) begin
            if (resp_q.size() == 0) begin
               chk("unexpected_done", {i_done, d_done}, 0);
            end else begin
               mr = resp_q.pop_front();
               chk("done_cycle", cyc, mr.cyc);
               chk("done_port", {i_done, d_done}, (mr.port == P_D) ? 2'b01 : 2'b10);
               if (mr.load) chk("rdata", (mr.port == P_D) ? d_rdata : i_rdata, mr.data);
            end
         end
         if ((mem_re || mem_we) && !(cyc >= ign_lo && cyc <= ign_hi)) begin
            if (acc_q.size() == 0) begin
               chk("unexpected_strobe", {mem_re, mem_we}, 0);
            end else begin
               ma = acc_q.pop_front();
               chk("acc_cycle", cyc, ma.cyc);
               chk("acc_addr", mem_addr, ma.addr);
               chk("acc_strobe", {mem_we, mem_re}, ma.we ? 2'b10 : 2'b01);
               if (ma.we) chk("acc_wdata", mem_wdata, ma.wdata);
            end
         end
      end
   end

   initial begin
      int t;
      int sel;
      bit p;
      rst = 1'b1; i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      last_port = P_D;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[8'h10] = 8'hDE; mem[8'h11] = 8'hAD; mem[8'h12] = 8'hBE; mem[8'h13] = 8'hEF;
      for (int i = 0; i < 4; i++) ref_mem[8'h10 + i] = mem[8'h10 + i];

      repeat (3) tick();
      @(negedge clk);
      chk_outputs_zero("reset");
      tick();
      rst = 1'b0;

      do_txn(P_I, 1'b0, 8'h10, '0);
      chk("fetch_word", i_rdata, 32'hDEADBEEF);
      do_txn(P_D, 1'b1, 8'h20, 32'h11223344);
      do_txn(P_D, 1'b0, 8'h20, '0);
      chk("load_back", d_rdata, 32'h11223344);
      chk("fetch_hold", i_rdata, 32'hDEADBEEF);
      do_tie(8'h10, 1'b0, 8'h20, '0);
      do_txn(P_I, 1'b0, 8'hFE, '0);

      // Flush mid-fetch: no strobes from T+4, no i_done, then a normal fetch.
      t = cyc;
      ign_lo = t + 1; ign_hi = t + 3;
      i_req = 1'b1; i_addr = 8'h40;
      repeat (3) tick();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0; i_req = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("flush_strobes_low", {mem_re, mem_we}, 0);
         chk("flush_no_done", i_done, 0);
         tick();
      end
      do_txn(P_I, 1'b0, 8'h80, '0);

      // Flush in IDLE blocks arbitration for that cycle only.
      i_req = 1'b1; i_addr = 8'h90; i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      do_txn(P_I, 1'b0, 8'h90, '0);

      // Reset during ISSUE of a load abandons it.
      t = cyc;
      ign_lo = t + 1; ign_hi = t + 2;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; d_req = 1'b0;
      last_port = P_D;
      @(negedge clk);
      chk_outputs_zero("midreset");
      tick();
      tick();

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 2) begin
            do_tie(8'($urandom), 1'($urandom), 8'($urandom), $urandom);
         end else begin
            p = 1'($urandom);
            do_txn(p, (p == P_D) ? 1'($urandom) : 1'b0, 8'($urandom), $urandom);
         end
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (10) tick();
      chk("resp_queue_drained", resp_q.size(), 0);
      chk("acc_queue_drained", acc_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
